vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 64 ++++++
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_axis_counter.sv | 37 +++
 rtl/vga_timing_gen.sv | 99 +++++++++
 tb/tb_vga_timing_gen.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Mode encoding, per-mode VGA timing table and frame totals shared by the
// timing generator and its axis counters.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    MODE_640X480  = 2'd0,
    MODE_800X600  = 2'd1,
    MODE_1024X768 = 2'd2,
    MODE_RESERVED = 2'd3
  } vga_mode_e;

  // One axis: active, front porch, sync, back porch, sync polarity (1 = positive)
  typedef struct packed {
    logic [15:0] act;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
    logic        pos_pol;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } mode_timing_t;

  localparam mode_timing_t TIMING_640 = '{
    h: '{act: 16'd640,  fp: 16'd16, sync: 16'd96,  bp: 16'd48,  pos_pol: 1'b0},
    v: '{act: 16'd480,  fp: 16'd10, sync: 16'd2,   bp: 16'd33,  pos_pol: 1'b0}
  };
  localparam mode_timing_t TIMING_800 = '{
    h: '{act: 16'd800,  fp: 16'd40, sync: 16'd128, bp: 16'd88,  pos_pol: 1'b1},
    v: '{act: 16'd600,  fp: 16'd1,  sync: 16'd4,   bp: 16'd23,  pos_pol: 1'b1}
  };
  localparam mode_timing_t TIMING_1024 = '{
    h: '{act: 16'd1024, fp: 16'd24, sync: 16'd136, bp: 16'd160, pos_pol: 1'b0},
    v: '{act: 16'd768,  fp: 16'd3,  sync: 16'd6,   bp: 16'd29,  pos_pol: 1'b0}
  };

  localparam logic [15:0] H_TOTAL_640  = 16'd800;
  localparam logic [15:0] V_TOTAL_640  = 16'd525;
  localparam logic [15:0] H_TOTAL_800  = 16'd1056;
  localparam logic [15:0] V_TOTAL_800  = 16'd628;
  localparam logic [15:0] H_TOTAL_1024 = 16'd1344;
  localparam logic [15:0] V_TOTAL_1024 = 16'd806;

  // Largest count any axis must reach; the counters must hold it.
  localparam int MAX_TOTAL = 1344;

  // The reserved code never becomes active, so it falls back to the largest mode.
  function automatic mode_timing_t mode_timing(input logic [1:0] mode);
    mode_timing_t t;
    case (mode)
      MODE_640X480: t = TIMING_640;
      MODE_800X600: t = TIMING_800;
      default:      t = TIMING_1024;
    endcase
    return t;
  endfunction

  function automatic logic [15:0] axis_total(input axis_timing_t t);
    return t.act + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel strobe / mode request in, sync, blanking, coordinates and event
// pulses out.
interface vga_timing_gen_if #(
  parameter int COORD_W = 11
);
  logic               i_pix_stb;
  logic [1:0]         i_mode;
  logic               o_hs;
  logic               o_vs;
  logic               o_de;
  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic               o_line_start;
  logic               o_frame_start;
  logic               o_animate;
  logic [1:0]         o_mode;

  modport master (
    output i_pix_stb, i_mode,
    input  o_hs, o_vs, o_de, o_x, o_y, o_line_start, o_frame_start, o_animate, o_mode
  );

  modport slave (
    input  i_pix_stb, i_mode,
    output o_hs, o_vs, o_de, o_x, o_y, o_line_start, o_frame_start, o_animate, o_mode
  );
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one display axis. Advances on i_en and
// returns to zero after reaching i_limit; o_wrap flags the wrapping cycle.
module vga_axis_counter #(
  parameter int COORD_W = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_limit,
  output logic [COORD_W-1:0] o_count,
  output logic               o_wrap
);

  logic [COORD_W-1:0] count_q;
  logic [COORD_W-1:0] count_d;

  // Next count: hold when idle, wrap to zero at the limit, else increment.
  always_comb begin
    o_wrap  = i_en && (count_q == i_limit);
    count_d = count_q;
    if (i_en) begin
      count_d = o_wrap ? '0 : count_q + COORD_W'(1);
    end
  end

  // Count register; reset takes priority over any enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with three selectable modes. Horizontal and
// vertical counters advance on the pixel strobe; all display outputs decode
// combinationally from the counters and the mode latched at frame wrap.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int         COORD_W      = 11,
  parameter logic [1:0] DEFAULT_MODE = 2'd2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  vga_timing_gen_if.slave bus
);

  if ((1 << COORD_W) <= MAX_TOTAL) begin : g_coord_w_check
    $error("COORD_W too narrow for the largest frame total");
  end

  if (axis_total(TIMING_640.h)  != H_TOTAL_640  || axis_total(TIMING_640.v)  != V_TOTAL_640  ||
      axis_total(TIMING_800.h)  != H_TOTAL_800  || axis_total(TIMING_800.v)  != V_TOTAL_800  ||
      axis_total(TIMING_1024.h) != H_TOTAL_1024 || axis_total(TIMING_1024.v) != V_TOTAL_1024)
  begin : g_total_check
    $error("timing table does not add up to the frame totals");
  end

  logic [1:0]         mode_q;
  logic [1:0]         mode_d;
  mode_timing_t       tim;
  logic [COORD_W-1:0] h_act, h_sync_beg, h_sync_end, h_last;
  logic [COORD_W-1:0] v_act, v_sync_beg, v_sync_end, v_last;
  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_wrap, v_wrap;
  logic               h_sync_on, v_sync_on;

  // Axis boundaries for the mode currently in effect.
  always_comb begin
    tim        = mode_timing(mode_q);
    h_act      = COORD_W'(tim.h.act);
    h_sync_beg = COORD_W'(tim.h.act + tim.h.fp);
    h_sync_end = COORD_W'(tim.h.act + tim.h.fp + tim.h.sync);
    h_last     = COORD_W'(axis_total(tim.h) - 16'd1);
    v_act      = COORD_W'(tim.v.act);
    v_sync_beg = COORD_W'(tim.v.act + tim.v.fp);
    v_sync_end = COORD_W'(tim.v.act + tim.v.fp + tim.v.sync);
    v_last     = COORD_W'(axis_total(tim.v) - 16'd1);
  end

  vga_axis_counter #(.COORD_W(COORD_W)) u_h_axis (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (bus.i_pix_stb),
    .i_limit (h_last),
    .o_count (h_cnt),
    .o_wrap  (h_wrap)
  );

  vga_axis_counter #(.COORD_W(COORD_W)) u_v_axis (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (h_wrap),
    .i_limit (v_last),
    .o_count (v_cnt),
    .o_wrap  (v_wrap)
  );

  // Mode request is taken only at the frame wrap, so a frame never mixes
  // timings; the reserved code is ignored.
  always_comb begin
    mode_d = mode_q;
    if (v_wrap && (bus.i_mode != 2'(MODE_RESERVED))) begin
      mode_d = bus.i_mode;
    end
  end

  // Active-mode register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q <= DEFAULT_MODE;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Zero-latency decode of sync, blanking, clamped coordinates and pulses.
  always_comb begin
    h_sync_on         = (h_cnt >= h_sync_beg) && (h_cnt < h_sync_end);
    v_sync_on         = (v_cnt >= v_sync_beg) && (v_cnt < v_sync_end);
    bus.o_hs          = tim.h.pos_pol ? h_sync_on : ~h_sync_on;
    bus.o_vs          = tim.v.pos_pol ? v_sync_on : ~v_sync_on;
    bus.o_de          = (h_cnt < h_act) && (v_cnt < v_act);
    bus.o_x           = (h_cnt < h_act) ? h_cnt : h_act - COORD_W'(1);
    bus.o_y           = (v_cnt < v_act) ? v_cnt : v_act - COORD_W'(1);
    bus.o_line_start  = h_wrap;
    bus.o_frame_start = v_wrap;
    bus.o_animate     = h_wrap && (v_cnt == v_act - COORD_W'(1));
    bus.o_mode        = mode_q;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: reset state, sync placement and
// polarity per mode, strobe gating, mode switching at frame wrap and
// mid-frame reset. Counter positions deep in a frame are reached by
// briefly forcing the axis counters.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COORD_W(11)) bus ();

  vga_timing_gen #(.COORD_W(11), .DEFAULT_MODE(2'd2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic jump(input logic [10:0] h, input logic [10:0] v);
    force dut.u_h_axis.count_q = h;
    force dut.u_v_axis.count_q = v;
    #1;
    release dut.u_h_axis.count_q;
    release dut.u_v_axis.count_q;
  endtask

  task automatic jump_h(input logic [10:0] h);
    force dut.u_h_axis.count_q = h;
    #1;
    release dut.u_h_axis.count_q;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.i_pix_stb = 1'b1; bus.i_mode = 2'd0;
    tick(); tick();
    bus.i_pix_stb = 1'b0;
    settle();
    n_cmp++; if (bus.o_mode !== 2'd2) begin n_bad++; $display("FAIL reset_mode: got %0d expected 2", bus.o_mode); end
    n_cmp++; if (bus.o_de !== 1'b1) begin n_bad++; $display("FAIL reset_de: got %b expected 1", bus.o_de); end
    n_cmp++; if (bus.o_x !== 11'd0 || bus.o_y !== 11'd0) begin n_bad++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", bus.o_x, bus.o_y); end
    n_cmp++; if ({bus.o_hs, bus.o_vs} !== 2'b11) begin n_bad++; $display("FAIL reset_sync: got %b expected 11", {bus.o_hs, bus.o_vs}); end
    n_cmp++; if ({bus.o_line_start, bus.o_frame_start, bus.o_animate} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b expected 000", {bus.o_line_start, bus.o_frame_start, bus.o_animate}); end
  endtask

  task automatic test_hsync_mode2();
    int first = -1; int last = -1; int nlow = 0; int nde = 0; int nls = 0; int ls_at = -1;
    logic [10:0] x_end = '0;
    tick();
    rst = 1'b0; bus.i_pix_stb = 1'b1; bus.i_mode = 2'd2;
    for (int i = 0; i < 1344; i++) begin
      settle();
      if (!bus.o_hs) begin if (first < 0) first = i; last = i; nlow++; end
      if (bus.o_de) nde++;
      if (bus.o_line_start) begin nls++; ls_at = i; end
      if (i == 1343) x_end = bus.o_x;
      tick();
    end
    settle();
    n_cmp++; if (first != 1048 || last != 1183) begin n_bad++; $display("FAIL m2_hs_window: got %0d..%0d expected 1048..1183", first, last); end
    n_cmp++; if (nlow != 136) begin n_bad++; $display("FAIL m2_hs_width: got %0d expected 136", nlow); end
    n_cmp++; if (nde != 1024) begin n_bad++; $display("FAIL m2_de_count: got %0d expected 1024", nde); end
    n_cmp++; if (nls != 1 || ls_at != 1343) begin n_bad++; $display("FAIL m2_line_start: got %0d pulses at %0d expected 1 at 1343", nls, ls_at); end
    n_cmp++; if (x_end !== 11'd1023) begin n_bad++; $display("FAIL m2_x_clamp: got %0d expected 1023", x_end); end
    n_cmp++; if (bus.o_y !== 11'd1 || bus.o_x !== 11'd0) begin n_bad++; $display("FAIL m2_next_line: got %0d,%0d expected 0,1", bus.o_x, bus.o_y); end
  endtask

  task automatic test_vsync_mode2();
    int first = -1; int last = -1; int nlow = 0; int nan = 0; int an_v = -1; int nfs = 0; int fs_v = -1; int nls = 0;
    jump(11'd1200, 11'd780);
    #1;
    n_cmp++; if (bus.o_x !== 11'd1023 || bus.o_y !== 11'd767 || bus.o_de !== 1'b0) begin n_bad++; $display("FAIL m2_blank_clamp: got x=%0d y=%0d de=%b expected 1023 767 0", bus.o_x, bus.o_y, bus.o_de); end
    tick();
    jump(11'd1343, 11'd766);
    for (int v = 766; v <= 805; v++) begin
      settle();
      if (!bus.o_vs) begin if (first < 0) first = v; last = v; nlow++; end
      if (bus.o_animate) begin nan++; an_v = v; end
      if (bus.o_frame_start) begin nfs++; fs_v = v; end
      if (bus.o_line_start) nls++;
      tick();
      if (v != 805) jump_h(11'd1343);
    end
    settle();
    n_cmp++; if (first != 771 || last != 776 || nlow != 6) begin n_bad++; $display("FAIL m2_vs_window: got %0d..%0d (%0d) expected 771..776 (6)", first, last, nlow); end
    n_cmp++; if (nan != 1 || an_v != 767) begin n_bad++; $display("FAIL m2_animate: got %0d at v=%0d expected 1 at 767", nan, an_v); end
    n_cmp++; if (nfs != 1 || fs_v != 805) begin n_bad++; $display("FAIL m2_frame_start: got %0d at v=%0d expected 1 at 805", nfs, fs_v); end
    n_cmp++; if (nls != 40) begin n_bad++; $display("FAIL m2_line_pulses: got %0d expected 40", nls); end
    n_cmp++; if (bus.o_x !== 11'd0 || bus.o_y !== 11'd0 || bus.o_vs !== 1'b1) begin n_bad++; $display("FAIL m2_wrap_origin: got %0d,%0d vs=%b expected 0,0 1", bus.o_x, bus.o_y, bus.o_vs); end
  endtask

  task automatic test_hold_and_switch();
    bus.i_pix_stb = 1'b0; bus.i_mode = 2'd0;
    jump(11'd1343, 11'd805);
    #1;
    n_cmp++; if ({bus.o_line_start, bus.o_frame_start, bus.o_animate} !== 3'b000) begin n_bad++; $display("FAIL hold_pulses: got %b expected 000", {bus.o_line_start, bus.o_frame_start, bus.o_animate}); end
    tick(); tick(); tick();
    settle();
    n_cmp++; if (bus.o_mode !== 2'd2 || bus.o_x !== 11'd1023 || bus.o_y !== 11'd767) begin n_bad++; $display("FAIL hold_state: got mode=%0d x=%0d y=%0d expected 2 1023 767", bus.o_mode, bus.o_x, bus.o_y); end
    bus.i_pix_stb = 1'b1;
    #1;
    n_cmp++; if (bus.o_frame_start !== 1'b1) begin n_bad++; $display("FAIL switch_fs: got %b expected 1", bus.o_frame_start); end
    tick();
    settle();
    n_cmp++; if (bus.o_mode !== 2'd0 || bus.o_x !== 11'd0 || bus.o_y !== 11'd0 || bus.o_hs !== 1'b1) begin n_bad++; $display("FAIL switch_mode0: got mode=%0d x=%0d y=%0d hs=%b expected 0 0 0 1", bus.o_mode, bus.o_x, bus.o_y, bus.o_hs); end
  endtask

  task automatic test_strobe_mode0();
    int t1 = -1; int t2 = -1; int nde = 0;
    logic [10:0] x_hold = '0;
    bus.i_pix_stb = 1'b0;
    for (int c = 0; c < 6400; c++) begin
      tick();
      bus.i_pix_stb = (c % 4 == 0);
      settle();
      if (bus.o_line_start) begin if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c; end
      if (c < 3200 && bus.i_pix_stb && bus.o_de) nde++;
      if (c == 3) x_hold = bus.o_x;
    end
    n_cmp++; if (t1 != 3196) begin n_bad++; $display("FAIL m0_first_line_start: got %0d expected 3196", t1); end
    n_cmp++; if (t2 - t1 != 3200) begin n_bad++; $display("FAIL m0_line_period: got %0d expected 3200", t2 - t1); end
    n_cmp++; if (nde != 640) begin n_bad++; $display("FAIL m0_de_strobes: got %0d expected 640", nde); end
    n_cmp++; if (x_hold !== 11'd1) begin n_bad++; $display("FAIL m0_hold_x: got %0d expected 1", x_hold); end
    bus.i_pix_stb = 1'b0;
    jump(11'd100, 11'd479);
    #1;
    n_cmp++; if (bus.o_de !== 1'b1 || bus.o_y !== 11'd479) begin n_bad++; $display("FAIL m0_last_line: got de=%b y=%0d expected 1 479", bus.o_de, bus.o_y); end
    jump(11'd100, 11'd480);
    #1;
    n_cmp++; if (bus.o_de !== 1'b0 || bus.o_y !== 11'd479) begin n_bad++; $display("FAIL m0_vblank: got de=%b y=%0d expected 0 479", bus.o_de, bus.o_y); end
  endtask

  task automatic test_mode_change();
    int first = -1; int last = -1; int nhi = 0; int nls = 0; int ls_at = -1;
    bus.i_pix_stb = 1'b1; bus.i_mode = 2'd2;
    jump(11'd0, 11'd100);
    tick();
    settle();
    n_cmp++; if (bus.o_mode !== 2'd0 || bus.o_hs !== 1'b1) begin n_bad++; $display("FAIL midframe_mode: got mode=%0d hs=%b expected 0 1", bus.o_mode, bus.o_hs); end
    bus.i_mode = 2'd1;
    jump(11'd300, 11'd500);
    #1;
    n_cmp++; if (bus.o_mode !== 2'd0) begin n_bad++; $display("FAIL midframe_mode_late: got %0d expected 0", bus.o_mode); end
    jump(11'd799, 11'd524);
    #1;
    n_cmp++; if (bus.o_frame_start !== 1'b1 || bus.o_mode !== 2'd0) begin n_bad++; $display("FAIL m0_wrap: got fs=%b mode=%0d expected 1 0", bus.o_frame_start, bus.o_mode); end
    tick();
    settle();
    n_cmp++; if (bus.o_mode !== 2'd1 || bus.o_x !== 11'd0 || bus.o_y !== 11'd0) begin n_bad++; $display("FAIL m1_enter: got mode=%0d x=%0d y=%0d expected 1 0 0", bus.o_mode, bus.o_x, bus.o_y); end
    for (int i = 0; i < 1056; i++) begin
      if (bus.o_hs) begin if (first < 0) first = i; last = i; nhi++; end
      if (bus.o_line_start) begin nls++; ls_at = i; end
      tick();
      settle();
    end
    n_cmp++; if (first != 840 || last != 967 || nhi != 128) begin n_bad++; $display("FAIL m1_hs_window: got %0d..%0d (%0d) expected 840..967 (128)", first, last, nhi); end
    n_cmp++; if (nls != 1 || ls_at != 1055) begin n_bad++; $display("FAIL m1_line_start: got %0d at %0d expected 1 at 1055", nls, ls_at); end
  endtask

  task automatic test_reserved();
    bus.i_mode = 2'd3;
    jump(11'd1055, 11'd627);
    #1;
    n_cmp++; if (bus.o_frame_start !== 1'b1) begin n_bad++; $display("FAIL rsv_fs: got %b expected 1", bus.o_frame_start); end
    tick();
    settle();
    n_cmp++; if (bus.o_mode !== 2'd1 || bus.o_y !== 11'd0) begin n_bad++; $display("FAIL rsv_mode: got mode=%0d y=%0d expected 1 0", bus.o_mode, bus.o_y); end
    jump(11'd1055, 11'd626);
    #1;
    n_cmp++; if (bus.o_frame_start !== 1'b0 || bus.o_line_start !== 1'b1) begin n_bad++; $display("FAIL rsv_no_early_wrap: got fs=%b ls=%b expected 0 1", bus.o_frame_start, bus.o_line_start); end
    tick();
    settle();
    n_cmp++; if (bus.o_y !== 11'd599 || bus.o_de !== 1'b0) begin n_bad++; $display("FAIL rsv_last_line: got y=%0d de=%b expected 599 0", bus.o_y, bus.o_de); end
    jump(11'd1055, 11'd627);
    #1;
    n_cmp++; if (bus.o_frame_start !== 1'b1) begin n_bad++; $display("FAIL rsv_total: got fs=%b expected 1", bus.o_frame_start); end
  endtask

  task automatic test_reset_mid();
    jump(11'd500, 11'd300);
    rst = 1'b1; bus.i_pix_stb = 1'b1; bus.i_mode = 2'd0;
    tick();
    settle();
    n_cmp++; if (bus.o_mode !== 2'd2 || bus.o_x !== 11'd0 || bus.o_y !== 11'd0 || bus.o_de !== 1'b1) begin n_bad++; $display("FAIL rstmid_state: got mode=%0d x=%0d y=%0d de=%b expected 2 0 0 1", bus.o_mode, bus.o_x, bus.o_y, bus.o_de); end
    n_cmp++; if ({bus.o_line_start, bus.o_frame_start, bus.o_animate} !== 3'b000 || {bus.o_hs, bus.o_vs} !== 2'b11) begin n_bad++; $display("FAIL rstmid_outputs: got pulses=%b sync=%b expected 000 11", {bus.o_line_start, bus.o_frame_start, bus.o_animate}, {bus.o_hs, bus.o_vs}); end
    rst = 1'b0;
    tick();
    settle();
    n_cmp++; if (bus.o_x !== 11'd1 || bus.o_mode !== 2'd2) begin n_bad++; $display("FAIL rstmid_resume: got x=%0d mode=%0d expected 1 2", bus.o_x, bus.o_mode); end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_pix_stb = 1'b0;
    bus.i_mode = 2'd2;
    test_reset();
    test_hsync_mode2();
    test_vsync_mode2();
    test_hold_and_switch();
    test_strobe_mode0();
    test_mode_change();
    test_reserved();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
